period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square wave (e.g. a divided blink clock or external tick) in units of the fast system clock. It is the inverse of the clock divider: the divider turns a fast clock into a slow one, and this block turns a slow waveform back into a cycle count. Results feed LED/seven-segment display logic and self-check benches through a one-cycle `valid` strobe. A sticky `timeout` flag reports a missing or stalled input.

---
 rtl/period_meter.sv | 138 +++++++++++++
 tb/tb_period_meter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow asynchronous square wave in clock_in cycles.
// Define PERIOD_METER_DUTY_EN to build fall detection and high-time capture; otherwise high_time reads 0.
module period_meter #(
    parameter int unsigned      WIDTH      = 28,
    parameter logic [WIDTH-1:0] MAX_PERIOD = 28'd200000
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;   // [0],[1] synchronizer, [2] previous value for edge detect
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             rise;

    assign rise = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        sync_d    = {sync_q[1:0], sig_in};
        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = ARM;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = WIDTH'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise on the very cycle the count reaches the limit is still a valid period.
                    if (rise) begin
                        period_d  = cnt_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = WIDTH'(1);
                    end else if (cnt_q == MAX_PERIOD) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

`ifdef PERIOD_METER_DUTY_EN
    logic             fall, capture, arm_hit;
    logic             fell_q, fell_d;
    logic [WIDTH-1:0] hi_shadow_q, hi_shadow_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;

    assign fall    = ~sync_q[1] & sync_q[2];
    assign capture = en & (state_q == MEASURE) & rise;
    assign arm_hit = en & (state_q == ARM) & rise;

    always_comb begin
        fell_d      = fell_q;
        hi_shadow_d = hi_shadow_q;
        high_time_d = high_time_q;
        // With no fall since the last rise the input was high the whole period.
        if (capture) begin
            high_time_d = fell_q ? hi_shadow_q : cnt_q;
        end
        if (capture || arm_hit) begin
            fell_d = 1'b0;
        end else if (en && (state_q == MEASURE) && fall) begin
            fell_d      = 1'b1;
            hi_shadow_d = cnt_q;
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            fell_q      <= 1'b0;
            hi_shadow_q <= '0;
            high_time_q <= '0;
        end else begin
            fell_q      <= fell_d;
            hi_shadow_q <= hi_shadow_d;
            high_time_q <= high_time_d;
        end
    end

    assign high_time = high_time_q;
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: directed phase patterns plus random phases, checked against an
// event-level reference model working on sample indices of sig_in.
module tb_period_meter;
    localparam int W    = 16;
    localparam int MAXP = 50;
`ifdef PERIOD_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         sig_in = 1'b0;
    logic [W-1:0] period, high_time;
    logic         valid, timeout;

    period_meter #(.WIDTH(W), .MAX_PERIOD(16'd50)) dut (
        .clock_in (clk),
        .reset_n  (reset_n),
        .en       (en),
        .sig_in   (sig_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: results follow from rise/fall sample indices alone.
    typedef struct {
        int per;
        int hi;
        bit chained;
    } res_t;

    res_t exp_q[$];
    bit   m_prev, m_meas, m_fell, m_chain, m_to;
    int   m_k, m_t0, m_tf, m_to_cnt;

    function automatic void model_step(bit s);
        bit r = s & !m_prev;
        bit f = !s & m_prev;
        m_k++;
        if (m_meas && f) begin
            m_fell = 1'b1;
            m_tf   = m_k;
        end
        if (r) begin
            if (m_meas) begin
                res_t e;
                e.per     = m_k - m_t0;
                e.hi      = DUTY ? (m_fell ? m_tf - m_t0 : e.per) : 0;
                e.chained = m_chain;
                exp_q.push_back(e);
                m_chain = 1'b1;
                m_to    = 1'b0;
            end else begin
                m_meas  = 1'b1;
                m_chain = 1'b0;
            end
            m_t0   = m_k;
            m_fell = 1'b0;
        end else if (m_meas && (m_k - m_t0 == MAXP)) begin
            m_meas  = 1'b0;
            m_chain = 1'b0;
            if (!m_to) m_to_cnt++;
            m_to = 1'b1;
        end
        m_prev = s;
    endfunction

    function automatic void model_abort();
        m_meas  = 1'b0;
        m_chain = 1'b0;
        m_to    = 1'b0;
    endfunction

    task automatic cyc(bit s, bit e, bit rn);
        @(negedge clk);
        sig_in  = s;
        en      = e;
        reset_n = rn;
        model_step(s);
        if (!e || !rn) model_abort();
    endtask

    task automatic phases(int lo, int hi, int n);
        for (int i = 0; i < n; i++) begin
            repeat (lo) cyc(1'b0, 1'b1, 1'b1);
            repeat (hi) cyc(1'b1, 1'b1, 1'b1);
        end
    endtask

    // Output monitor: scoreboard compare, spacing and timeout-onset counting.
    int cyc_n = 0, last_v = 0, nvalid = 0, dut_to_cnt = 0;
    bit prev_v = 1'b0, prev_to = 1'b0;

    always @(negedge clk) begin
        cyc_n++;
        if (valid) begin
            nvalid++;
            chk("valid_b2b", prev_v, 1'b0);
            chk("exp_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                res_t e;
                e = exp_q.pop_front();
                chk("period", period, e.per);
                chk("high_time", high_time, e.hi);
                chk("timeout_on_valid", timeout, 1'b0);
                if (e.chained) chk("valid_gap", cyc_n - last_v, e.per);
            end
            last_v = cyc_n;
        end
        if (timeout && !prev_to) dut_to_cnt++;
        prev_v  = valid;
        prev_to = timeout;
    end

    int nv0;

    initial begin
        // Reset, then armed with a quiet input: nothing may happen.
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_valid", valid, 0);
        chk("rst_timeout", timeout, 0);
        nv0 = nvalid;
        repeat (MAXP + 10) cyc(1'b0, 1'b1, 1'b1);
        chk("idle_nvalid", nvalid - nv0, 0);
        chk("idle_timeout", timeout, 0);
        chk("idle_period", period, 0);

        phases(5, 5, 8);
        chk("even_period", period, 10);
        chk("even_high", high_time, DUTY ? 5 : 0);

        phases(3, 4, 8);
        chk("odd_period", period, 7);
        chk("odd_high", high_time, DUTY ? 4 : 0);

        phases(10, 10, 4);
        repeat (60) cyc(1'b0, 1'b1, 1'b1);
        chk("to_set", timeout, 1);
        chk("to_period_kept", period, 20);
        phases(10, 10, 3);
        chk("to_cleared", timeout, 0);
        chk("to_resume_period", period, 20);

        // en dropped for one cycle in the middle of a low phase.
        phases(12, 12, 3);
        repeat (6) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (5) cyc(1'b0, 1'b1, 1'b1);
        repeat (12) cyc(1'b1, 1'b1, 1'b1);
        phases(12, 12, 3);
        chk("en_abort_period", period, 24);

        // Reset pulse in the middle of a low phase.
        repeat (6) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("midrst_period", period, 0);
        chk("midrst_high", high_time, 0);
        chk("midrst_timeout", timeout, 0);
        repeat (4) cyc(1'b0, 1'b1, 1'b1);
        repeat (12) cyc(1'b1, 1'b1, 1'b1);
        phases(12, 12, 3);
        chk("rst_resume_period", period, 24);

        // Period exactly MAX_PERIOD: rise wins; one more cycle times out.
        phases(25, 25, 4);
        chk("coll_period", period, MAXP);
        chk("coll_timeout", timeout, 0);
        phases(26, 25, 3);
        chk("over_timeout", timeout, 1);
        chk("over_period", period, MAXP);

        for (int i = 0; i < 300; i++) begin
            int lo, hi;
            lo = ($urandom_range(0, 15) == 0) ? 35 : $urandom_range(2, 30);
            hi = $urandom_range(2, 30);
            phases(lo, hi, 1);
        end

        repeat (MAXP + 20) cyc(1'b0, 1'b1, 1'b1);
        chk("sb_drained", exp_q.size(), 0);
        chk("timeout_events", dut_to_cnt, m_to_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
